// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: data widths, opcodes and the code-loader FSM states.
// The CHK state exists only when CODE_LOADER_CHECKSUM_EN is defined.
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int DATA_W  = 8;

  localparam logic [3:0] LINP = 4'b1000;
  localparam logic [3:0] WOUT = 4'b1010;
  localparam logic [3:0] JAL  = 4'b0110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LEN,
    S_HI,
    S_LO,
`ifdef CODE_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_RUN,
    S_ERR
  } state_t;

endpackage

// File: rtl/code_loader_if.sv
// Byte-source valid/ready channel feeding the code loader.
interface code_loader_if;
  import cpu_pkg::*;

  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              src_ready;

  modport master (output src_valid, output src_data, input src_ready);
  modport slave  (input src_valid, input src_data, output src_ready);

endinterface

// File: rtl/code_loader_byte_pair_assembler.sv
// Latches the high byte and emits the completed instruction word with a one-cycle strobe.
module byte_pair_assembler
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hi_load,
  input  logic               lo_load,
  input  logic [DATA_W-1:0]  data,
  output logic [INSTR_W-1:0] word,
  output logic               word_strobe
);

  logic [DATA_W-1:0]  hi_reg;
  logic [INSTR_W-1:0] word_reg;
  logic               strobe_reg;

  // The word is only driven during its strobe cycle; otherwise the bus idles at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_reg     <= '0;
      word_reg   <= '0;
      strobe_reg <= 1'b0;
    end else begin
      strobe_reg <= lo_load;
      if (hi_load) begin
        hi_reg <= data;
      end
      word_reg <= lo_load ? {hi_reg, data} : '0;
    end
  end

  assign word        = word_reg;
  assign word_strobe = strobe_reg;

endmodule

// File: rtl/code_loader.sv
// Loads a length-prefixed byte stream into CPU code memory, then releases the CPU from reset.
// Define CODE_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before RUN.
module code_loader
  import cpu_pkg::*;
#(
  parameter int MAX_WORDS    = 64,
  parameter int CLEAR_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  code_loader_if.slave                   src,
  output logic                           clear_code,
  output logic                           getcode,
  output logic [INSTR_W-1:0]             instruction_in,
  output logic                           cpu_reset_n,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_count
);

  localparam int WC_W  = $clog2(MAX_WORDS + 1);
  localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  state_t            state_reg;
  logic [CNT_W-1:0]  clear_cnt_reg;
  logic [DATA_W-1:0] len_reg;
  logic [WC_W-1:0]   word_count_reg;
  logic              clear_code_reg;
  logic              cpu_reset_n_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              error_reg;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] xor_reg;
`endif

  logic              ready_state;
  logic              accept;
  logic              len_bad;
  logic              last_word;
  logic [WC_W-1:0]   wc_inc;

  always_comb begin
    ready_state = 1'b0;
    case (state_reg)
      S_LEN, S_HI, S_LO: ready_state = 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
      S_CHK:             ready_state = 1'b1;
`endif
      default:           ready_state = 1'b0;
    endcase
  end

  // Ready drops during the write strobe so each word spends at least three cycles.
  assign src.src_ready = ready_state && !getcode;
  assign accept        = src.src_valid && src.src_ready;
  assign wc_inc        = word_count_reg + WC_W'(1);
  assign last_word     = (32'(wc_inc) == 32'(len_reg));
  assign len_bad       = (src.src_data == '0) || (32'(src.src_data) > 32'(MAX_WORDS));

  byte_pair_assembler u_assembler (
    .clk         (clk),
    .reset_n     (reset_n),
    .hi_load     (accept && (state_reg == S_HI)),
    .lo_load     (accept && (state_reg == S_LO)),
    .data        (src.src_data),
    .word        (instruction_in),
    .word_strobe (getcode)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      clear_cnt_reg   <= '0;
      len_reg         <= '0;
      word_count_reg  <= '0;
      clear_code_reg  <= 1'b0;
      cpu_reset_n_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
      xor_reg         <= '0;
`endif
    end else begin
      case (state_reg)
        S_IDLE, S_RUN, S_ERR: begin
          // The CPU is released one cycle after RUN is entered; a start overrides it.
          if (state_reg == S_RUN) begin
            cpu_reset_n_reg <= 1'b1;
          end
          if (start) begin
            state_reg       <= S_CLEAR;
            clear_cnt_reg   <= CNT_W'(CLEAR_CYCLES - 1);
            word_count_reg  <= '0;
            clear_code_reg  <= 1'b1;
            cpu_reset_n_reg <= 1'b0;
            busy_reg        <= 1'b1;
            done_reg        <= 1'b0;
            error_reg       <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
            xor_reg         <= '0;
`endif
          end
        end
        S_CLEAR: begin
          if (clear_cnt_reg == '0) begin
            clear_code_reg <= 1'b0;
            state_reg      <= S_LEN;
          end else begin
            clear_cnt_reg <= clear_cnt_reg - CNT_W'(1);
          end
        end
        S_LEN: begin
          if (accept) begin
            if (len_bad) begin
              state_reg <= S_ERR;
              busy_reg  <= 1'b0;
              error_reg <= 1'b1;
            end else begin
              len_reg   <= src.src_data;
              state_reg <= S_HI;
            end
          end
        end
        S_HI: begin
          if (accept) begin
            state_reg <= S_LO;
`ifdef CODE_LOADER_CHECKSUM_EN
            xor_reg   <= xor_reg ^ src.src_data;
`endif
          end
        end
        S_LO: begin
          if (accept) begin
            word_count_reg <= wc_inc;
`ifdef CODE_LOADER_CHECKSUM_EN
            xor_reg        <= xor_reg ^ src.src_data;
            state_reg      <= last_word ? S_CHK : S_HI;
`else
            if (last_word) begin
              state_reg <= S_RUN;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_HI;
            end
`endif
          end
        end
`ifdef CODE_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            busy_reg <= 1'b0;
            if (src.src_data == xor_reg) begin
              state_reg <= S_RUN;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= S_ERR;
              error_reg <= 1'b1;
            end
          end
        end
`endif
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign clear_code  = clear_code_reg;
  assign cpu_reset_n = cpu_reset_n_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign error       = error_reg;
  assign word_count  = word_count_reg;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: directed scenarios plus randomized sessions against a byte-stream model.
// Checksum scenarios run only when CODE_LOADER_CHECKSUM_EN is defined.
module tb_code_loader;

  localparam int MAX_WORDS = 64;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [15:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        clear_code, getcode, cpu_reset_n, busy, done, error;
  logic [15:0] instruction_in;
  logic [6:0]  word_count;

  int          n_checks = 0;
  int          n_fail = 0;
  int          clr_cycles = 0;
  logic [15:0] got_q[$];

  code_loader_if sif();

  code_loader #(.MAX_WORDS(MAX_WORDS), .CLEAR_CYCLES(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .src            (sif),
    .clear_code     (clear_code),
    .getcode        (getcode),
    .instruction_in (instruction_in),
    .cpu_reset_n    (cpu_reset_n),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .word_count     (word_count)
  );

  always #5 clk = ~clk;

  // Observe the CPU-side write port on the falling edge.
  always @(negedge clk) begin
    if (getcode === 1'b1) got_q.push_back(instruction_in);
    if (clear_code === 1'b1) clr_cycles++;
    if (getcode === 1'b1 && clear_code === 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL clear_getcode_overlap: both high at %0t, required never together", $time);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: word i is byte[1+2i]*256 + byte[2+2i] of the stream.
  function automatic word_q_t model_words(input byte_q_t b);
    word_q_t w;
    int n;
    w = {};
    n = int'(b[0]);
    for (int i = 0; i < n; i++) w.push_back(16'(int'(b[1+2*i]) * 256 + int'(b[2+2*i])));
    return w;
  endfunction

  task automatic start_session();
    got_q.delete();
    clr_cycles = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({clear_code, busy, cpu_reset_n, done, error} !== 5'b11000) begin
      n_fail++;
      $display("FAIL session_start: clear/busy/cpu_rst/done/err=%b required 11000",
               {clear_code, busy, cpu_reset_n, done, error});
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    sif.src_valid = 1'b1;
    sif.src_data  = b;
    while (sif.src_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL ready_timeout: byte %h not accepted in 100 cycles, required acceptance", b);
    end else begin
      @(negedge clk);
    end
    sif.src_valid = 1'b0;
  endtask

  task automatic send_seq(input byte_q_t b, input int gap_max);
    foreach (b[i]) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      send_byte(b[i]);
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL end_timeout: neither done nor error within 50 cycles");
    end
    @(negedge clk);
  endtask

  task automatic check_session(input string name, input word_q_t exp_w, input bit exp_done,
                               input int exp_wc);
    n_checks++;
    if (got_q.size() != exp_w.size()) begin
      n_fail++;
      $display("FAIL %s word_cnt: %0d getcode pulses, required %0d", name, got_q.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_w[i]) begin
        n_fail++;
        $display("FAIL %s word[%0d]: got %h, required %h", name, i, got_q[i], exp_w[i]);
      end
    end
    n_checks++;
    if ({done, error, cpu_reset_n, busy} !== {exp_done, !exp_done, exp_done, 1'b0}) begin
      n_fail++;
      $display("FAIL %s status: done/err/cpu_rst/busy=%b required %b", name,
               {done, error, cpu_reset_n, busy}, {exp_done, !exp_done, exp_done, 1'b0});
    end
    n_checks++;
    if (int'(word_count) != exp_wc) begin
      n_fail++;
      $display("FAIL %s word_count: got %0d, required %0d", name, word_count, exp_wc);
    end
    n_checks++;
    if (clr_cycles != 1 || sif.src_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s clear/ready: clear cycles %0d ready %b, required 1 and 0", name,
               clr_cycles, sif.src_ready);
    end
  endtask

  task automatic test_reset();
    sif.src_valid = 1'b0;
    sif.src_data  = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({clear_code, getcode, cpu_reset_n, busy, done, error, sif.src_ready} !== 7'b0 ||
        instruction_in !== 16'h0 || word_count !== 7'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: flags=%b instr=%h wc=%0d required all 0",
               {clear_code, getcode, cpu_reset_n, busy, done, error, sif.src_ready},
               instruction_in, word_count);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({clear_code, getcode, cpu_reset_n, busy, done, error, sif.src_ready} !== 7'b0) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d: flags=%b required 0000000", i,
                 {clear_code, getcode, cpu_reset_n, busy, done, error, sif.src_ready});
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    byte_q_t b;
    b = '{8'h02, 8'h80, 8'h00, 8'hA0, 8'h00};
    start_session();
    send_seq(b, 0);
    wait_end();
    check_session("basic", '{16'h8000, 16'hA000}, 1'b1, 2);
    $display("test_basic: 2 words loaded");
  endtask

  task automatic test_len_errors();
    byte_q_t b;
    word_q_t none;
    logic [7:0] lens[3];
    none = {};
    lens[0] = 8'h00;
    lens[1] = 8'h41;
    lens[2] = 8'($urandom_range(MAX_WORDS + 1, 255));
    foreach (lens[i]) begin
      b = '{lens[i]};
      start_session();
      send_seq(b, 0);
      wait_end();
      check_session("len_error", none, 1'b0, 0);
      $display("test_len_errors: length %h rejected", lens[i]);
    end
  endtask

  task automatic test_stall();
    byte_q_t b;
    start_session();
    send_byte(8'h02);
    send_byte(8'h80);
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (got_q.size() != 0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stall: %0d getcode pulses busy=%b during stall, required 0 and 1", got_q.size(), busy);
    end
    b = '{8'h00, 8'hA0, 8'h00};
    send_seq(b, 0);
    wait_end();
    check_session("stall", '{16'h8000, 16'hA000}, 1'b1, 2);
    $display("test_stall: stall and ignored start handled");
  endtask

  task automatic test_reset_mid();
    byte_q_t b;
    start_session();
    send_byte(8'h02);
    send_byte(8'h80);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, cpu_reset_n, sif.src_ready, clear_code, getcode} !== 5'b0 || word_count !== 7'h0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: busy/cpu_rst/ready/clear/getcode=%b wc=%0d required 0",
               {busy, cpu_reset_n, sif.src_ready, clear_code, getcode}, word_count);
    end
    b = '{8'h01, 8'h60, 8'h00};
    start_session();
    send_seq(b, 0);
    wait_end();
    check_session("reset_mid", '{16'h6000}, 1'b1, 1);
    $display("test_reset_mid: recovered after reset");
  endtask

  task automatic test_random();
    byte_q_t b;
    int n;
    bit exp_done;
    logic [7:0] x;
    for (int s = 0; s < 8; s++) begin
      n = (s == 0) ? MAX_WORDS : (s == 1) ? 1 : $urandom_range(1, MAX_WORDS);
      b = '{8'(n)};
      x = 8'h00;
      for (int i = 0; i < 2 * n; i++) begin
        b.push_back(8'($urandom_range(0, 255)));
        x = x ^ b[b.size() - 1];
      end
      exp_done = 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
      exp_done = 1'($urandom_range(0, 1));
      b.push_back(exp_done ? x : (x ^ 8'($urandom_range(1, 255))));
`endif
      start_session();
      send_seq(b, 2);
      wait_end();
      check_session("random", model_words(b), exp_done, n);
      $display("test_random: session %0d N=%0d done_expected=%0d", s, n, exp_done);
    end
  endtask

`ifdef CODE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    byte_q_t b;
    b = '{8'h01, 8'h80, 8'h04, 8'h84};
    start_session();
    send_seq(b, 0);
    wait_end();
    check_session("chk_good", '{16'h8004}, 1'b1, 1);
    b = '{8'h01, 8'h80, 8'h04, 8'h85};
    start_session();
    send_seq(b, 0);
    wait_end();
    check_session("chk_bad", '{16'h8004}, 1'b0, 1);
    start_session();
    $display("test_checksum: good, bad and restart sessions");
  endtask
`endif

  initial begin
    sif.src_valid = 1'b0;
    sif.src_data  = '0;
    test_reset();
    test_basic();
    test_len_errors();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef CODE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
